// File: rtl/gigerx_frame_unload.sv
// gigerx_frame_unload: pops one byte-count entry per frame, reads that frame's words, emits a sop/eop/be/err stream.
// Optional feature macro GIGERX_UNLOAD_DROP_BAD_EN: frames flagged bad in entry bit 15 are read and discarded.
module gigerx_frame_unload #(
    parameter int DWIDTH = 64,
    parameter int BWIDTH = 16,
    parameter int CNTW   = 14
) (
    input  logic                rdclk,
    input  logic                reset_n,
    input  logic                bcnt_empty,
    output logic                bcnt_rdreq,
    input  logic [BWIDTH-1:0]   bcnt_q,
    input  logic                dat_empty,
    output logic                dat_rdreq,
    input  logic [DWIDTH-1:0]   dat_q,
    output logic                rx_valid,
    input  logic                rx_ready,
    output logic [DWIDTH-1:0]   rx_data,
    output logic                rx_sop,
    output logic                rx_eop,
    output logic [DWIDTH/8-1:0] rx_be,
    output logic                rx_err,
    output logic                len_err
);
    localparam int BEW = DWIDTH / 8;
    localparam int WW  = CNTW - 2;

    typedef enum logic [1:0] {IDLE, BCNT_WAIT, DATA, DROP} state_t;

    typedef struct packed {
        logic [DWIDTH-1:0] data;
        logic              sop;
        logic              eop;
        logic [BEW-1:0]    be;
        logic              err;
    } word_t;

    state_t         state_q, state_d;
    logic [WW-1:0]  rem_q, rem_d, words_c;
    logic [BEW-1:0] last_be_q, last_be_d, last_be_c;
    logic           bad_q, bad_d, first_q, first_d;
    logic           infl_q, drop_q;
    logic [BEW+2:0] tag_q, tag_d;
    word_t          mem_q [2];
    word_t          head;
    logic           wptr_q, rptr_q;
    logic [1:0]     cnt_q, occ_c;
    logic [CNTW-1:0] bcnt_c;
    logic           rd_bcnt, rd_dat, last_c, push, pop, room;
    logic           unused_bits;

    assign unused_bits = ^bcnt_q[BWIDTH-2:CNTW];
    assign bcnt_c      = bcnt_q[CNTW-1:0];
    assign words_c     = WW'(({1'b0, bcnt_c} + (CNTW+1)'(7)) >> 3);
    assign last_be_c   = (bcnt_c[2:0] == 3'd0) ? '1 : BEW'((BEW'(1) << bcnt_c[2:0]) - BEW'(1));
    assign last_c      = (rem_q == WW'(1));
    assign tag_d       = {first_q, last_c, last_c ? last_be_q : {BEW{1'b1}}, last_c & bad_q};

    // Occupancy counts the word leaving this cycle so a steady stream runs at one word per cycle.
    assign pop   = (cnt_q != 2'd0) && rx_ready;
    assign push  = infl_q && !drop_q;
    assign occ_c = cnt_q + {1'b0, infl_q} - {1'b0, pop};
    assign room  = (occ_c < 2'd2);

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        last_be_d = last_be_q;
        bad_d     = bad_q;
        first_d   = first_q;
        rd_bcnt   = 1'b0;
        rd_dat    = 1'b0;
        len_err   = 1'b0;
        case (state_q)
            IDLE: begin
                rd_bcnt = !bcnt_empty && !infl_q;
                state_d = rd_bcnt ? BCNT_WAIT : IDLE;
            end
            BCNT_WAIT: begin
                rem_d     = words_c;
                last_be_d = last_be_c;
                bad_d     = bcnt_q[BWIDTH-1];
                first_d   = 1'b1;
                len_err   = (bcnt_c == '0);
`ifdef GIGERX_UNLOAD_DROP_BAD_EN
                state_d   = len_err ? IDLE : (bcnt_q[BWIDTH-1] ? DROP : DATA);
`else
                state_d   = len_err ? IDLE : DATA;
`endif
            end
            DATA: rd_dat = !dat_empty && (rem_q != '0) && room;
`ifdef GIGERX_UNLOAD_DROP_BAD_EN
            DROP: rd_dat = !dat_empty && (rem_q != '0);
`endif
            default: state_d = IDLE;
        endcase
        if (rd_dat) begin
            rem_d   = rem_q - WW'(1);
            first_d = 1'b0;
            state_d = last_c ? IDLE : state_q;
        end
    end

    always_ff @(posedge rdclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            last_be_q <= '0;
            bad_q     <= 1'b0;
            first_q   <= 1'b0;
            infl_q    <= 1'b0;
            drop_q    <= 1'b0;
            tag_q     <= '0;
            mem_q     <= '{default: '0};
            wptr_q    <= 1'b0;
            rptr_q    <= 1'b0;
            cnt_q     <= 2'd0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            last_be_q <= last_be_d;
            bad_q     <= bad_d;
            first_q   <= first_d;
            infl_q    <= rd_dat;
            if (rd_dat) begin
                tag_q  <= tag_d;
                drop_q <= (state_q == DROP);
            end
            if (push) begin
                mem_q[wptr_q] <= {dat_q, tag_q};
                wptr_q        <= ~wptr_q;
            end
            if (pop) rptr_q <= ~rptr_q;
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head       = mem_q[rptr_q];
    assign rx_valid   = (cnt_q != 2'd0);
    assign rx_data    = rx_valid ? head.data : '0;
    assign rx_sop     = rx_valid && head.sop;
    assign rx_eop     = rx_valid && head.eop;
    assign rx_be      = rx_valid ? head.be : '0;
    assign rx_err     = rx_valid && head.err;
    assign bcnt_rdreq = rd_bcnt && reset_n;
    assign dat_rdreq  = rd_dat;
endmodule

// File: tb/tb_gigerx_frame_unload.sv
// tb_gigerx_frame_unload: directed and randomized frames checked against a frame-level expected-word model.
module tb_gigerx_frame_unload;
    logic        rdclk = 1'b0;
    logic        reset_n = 1'b0;
    logic        bcnt_empty, bcnt_rdreq, dat_empty, dat_rdreq;
    logic        rx_valid, rx_ready, rx_sop, rx_eop, rx_err, len_err;
    logic [15:0] bcnt_q = '0;
    logic [63:0] dat_q = '0;
    logic [63:0] rx_data;
    logic [7:0]  rx_be;

    typedef struct packed {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [7:0]  be;
        logic        err;
    } exp_t;

`ifdef GIGERX_UNLOAD_DROP_BAD_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic [15:0] bmem [256];
    int          bstart [256];
    logic [63:0] dmem [4096];
    int bwr = 0, brd = 0, dwr = 0, drd = 0;
    int pcyc = 0, rq_cyc = 0, order_err = 0, under_err = 0;
    int tests = 0, fails = 0;
    int lerr_seen = 0, lerr_exp = 0, acc_n = 0, rd_n = 0;
    int rdy_mode = 0;
    bit hold_mode = 0, lat_chk = 0, occ_chk = 0, prev_hold = 0;
    logic        dhold = 1'b0;
    logic [75:0] prev_out = '0;
    exp_t exp_q [$];

    gigerx_frame_unload dut (
        .rdclk(rdclk), .reset_n(reset_n),
        .bcnt_empty(bcnt_empty), .bcnt_rdreq(bcnt_rdreq), .bcnt_q(bcnt_q),
        .dat_empty(dat_empty), .dat_rdreq(dat_rdreq), .dat_q(dat_q),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
        .rx_sop(rx_sop), .rx_eop(rx_eop), .rx_be(rx_be), .rx_err(rx_err),
        .len_err(len_err)
    );

    always #5 rdclk = ~rdclk;

    assign bcnt_empty = (brd == bwr);
    assign dat_empty  = (drd == dwr) || dhold;

    // Standard-mode FIFO models: data appears the cycle after the read request.
    always @(posedge rdclk) begin
        pcyc <= pcyc + 1;
        if (!reset_n) begin
            brd <= bwr;
            drd <= dwr;
        end else begin
            if (bcnt_rdreq) begin
                rq_cyc <= pcyc + 1;
                if (brd == bwr) under_err <= under_err + 1;
                else begin
                    if (drd != bstart[brd]) order_err <= order_err + 1;
                    bcnt_q <= bmem[brd];
                    brd    <= brd + 1;
                end
            end
            if (dat_rdreq) begin
                if (dat_empty) under_err <= under_err + 1;
                else begin
                    dat_q <= dmem[drd];
                    drd   <= drd + 1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [13:0] bcnt, input bit bad);
        int n;
        int r;
        logic [63:0] w;
        n = (int'(bcnt) + 7) / 8;
        r = int'(bcnt) % 8;
        bmem[bwr]   = {bad, 1'b0, bcnt};
        bstart[bwr] = dwr;
        for (int i = 0; i < n; i++) begin
            w = {$urandom, $urandom};
            dmem[dwr] = w;
            dwr++;
            if (!(bad && DROP_EN))
                exp_q.push_back('{data: w, sop: (i == 0), eop: (i == n - 1),
                                  be: (i == n - 1 && r != 0) ? 8'((1 << r) - 1) : 8'hFF,
                                  err: (i == n - 1) && bad});
        end
        if (bcnt == 0) lerr_exp++;
        bwr++;
    endtask

    task automatic tick();
        exp_t e;
        @(negedge rdclk);
        rx_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? ~rx_ready : 1'($urandom_range(0, 1));
        dhold    = hold_mode ? ($urandom_range(0, 3) == 0) : 1'b0;
        #1;
        if (len_err) lerr_seen++;
        if (prev_hold) chk("hold_stable", {rx_valid, rx_data, rx_sop, rx_eop, rx_be, rx_err}, prev_out);
        if (!rx_valid) chk("idle_zero", {rx_data, rx_sop, rx_eop, rx_be, rx_err}, '0);
        if (rx_valid && lat_chk) begin
            chk("latency", pcyc - rq_cyc + 1, 4);
            lat_chk = 0;
        end
        if (occ_chk && dat_rdreq) rd_n++;
        if (rx_valid && rx_ready) begin
            acc_n++;
            chk("extra_word", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("data", rx_data, e.data);
                chk("tags", {rx_sop, rx_eop, rx_be, rx_err}, {e.sop, e.eop, e.be, e.err});
            end
        end
        if (occ_chk) chk("occupancy", (rd_n - acc_n) <= 2, 1'b1);
        prev_hold = rx_valid && !rx_ready;
        prev_out  = {rx_valid, rx_data, rx_sop, rx_eop, rx_be, rx_err};
    endtask

    task automatic drain(input int lim);
        int n;
        n = 0;
        while (n < lim && !(exp_q.size() == 0 && brd == bwr && drd == dwr && !rx_valid)) begin
            tick();
            n++;
        end
        chk("drain_timeout", n < lim, 1'b1);
        repeat (4) tick();
    endtask

    initial begin
        rx_ready = 1'b1;
        repeat (3) tick();
        chk("reset_outputs", {bcnt_rdreq, dat_rdreq, rx_valid, rx_sop, rx_eop, rx_err, len_err, rx_data, rx_be}, '0);
        reset_n = 1'b1;

        lat_chk = 1;
        push_frame(14'd64, 1'b0);
        drain(200);
        chk("latency_seen", lat_chk, 1'b0);

        push_frame(14'd61, 1'b0);
        push_frame(14'd1, 1'b0);
        drain(200);

        push_frame(14'd0, 1'b0);
        push_frame(14'd8, 1'b0);
        drain(200);
        chk("len_err_count", lerr_seen, lerr_exp);
        chk("frame_order", order_err, 0);

        push_frame(14'd64, 1'b1);
        push_frame(14'd16, 1'b0);
        drain(300);

        rdy_mode = 1;
        occ_chk  = 1;
        rd_n     = 0;
        acc_n    = 0;
        push_frame(14'd100, 1'b0);
        drain(300);
        occ_chk  = 0;
        rdy_mode = 0;
        chk("words_100", acc_n, 13);

        acc_n = 0;
        push_frame(14'd128, 1'b0);
        for (int i = 0; i < 100 && acc_n < 3; i++) tick();
        chk("reached_word3", acc_n, 3);
        reset_n = 1'b0;
        #1;
        chk("reset_async", {bcnt_rdreq, dat_rdreq, rx_valid, rx_sop, rx_eop, rx_err, len_err, rx_data, rx_be}, '0);
        exp_q.delete();
        prev_hold = 0;
        repeat (2) tick();
        chk("reset_held", {bcnt_rdreq, dat_rdreq, rx_valid, rx_sop, rx_eop, rx_err, len_err, rx_data, rx_be}, '0);
        reset_n = 1'b1;
        lat_chk = 1;
        push_frame(14'd8, 1'b0);
        drain(200);
        chk("latency_after_reset", lat_chk, 1'b0);

        rdy_mode  = 2;
        hold_mode = 1;
        for (int i = 0; i < 30; i++)
            push_frame(14'($urandom_range(0, 90)), $urandom_range(0, 3) == 0);
        drain(20000);
        hold_mode = 0;
        rdy_mode  = 0;

        chk("len_err_total", lerr_seen, lerr_exp);
        chk("frame_order_total", order_err, 0);
        chk("fifo_underflow", under_err, 0);
        chk("exp_left", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
